// File: rtl/pixie_pkg.sv
// Shared Pixie definitions: grant encoding and the default frame-buffer bus widths
// used by the front end, the scanout and the VRAM arbiter.
package pixie_pkg;

    localparam int PIXIE_ADDR_W = 10;
    localparam int PIXIE_DATA_W = 8;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_SCAN = 2'd1,
        GNT_DMA  = 2'd2,
        GNT_CPU  = 2'd3
    } gnt_e;

endpackage

// File: rtl/pixie_post_fifo.sv
// Synchronous posting FIFO for DMA writes. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise the push is ignored.
module pixie_post_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_FULL);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pixie_vram_arbiter.sv
// Pixie frame-buffer RAM arbiter: scanout, posted DMA writes and CPU share one RAM port.
// Define PIXIE_VRAM_STATS_EN to build the saturating contention counter on stat_conflicts.
module pixie_vram_arbiter
    import pixie_pkg::*;
#(
    parameter int ADDR_W       = PIXIE_ADDR_W,
    parameter int DATA_W       = PIXIE_DATA_W,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dma_wr_en,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_data,
    output logic              dma_overflow,
    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_ack,
    output logic [DATA_W-1:0] scan_rdata,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [15:0]       stat_conflicts
);

    localparam int FIFO_W   = ADDR_W + DATA_W;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_pop;
    logic [FIFO_W-1:0] fifo_head;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    logic              scan_elig;
    logic              dma_elig;
    logic              cpu_elig;
    gnt_e              gnt_p0;
    gnt_e              gnt_p1;
    logic              cpu_rd_p1;
    logic [STARVE_W-1:0] starve_cnt;
    logic [ADDR_W-1:0] addr_hold;
    logic [DATA_W-1:0] wdata_hold;
    logic              overflow_q;

    pixie_post_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (dma_wr_en),
        .push_data ({dma_addr, dma_data}),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign {head_addr, head_data} = fifo_head;

    // Stage p0: eligibility and grant. A requester whose ack is out this cycle
    // still holds its request, so it is masked to avoid a double grant.
    assign scan_elig = !reset && scan_req && (gnt_p1 != GNT_SCAN);
    assign dma_elig  = !reset && !fifo_empty;
    assign cpu_elig  = !reset && cpu_req && (gnt_p1 != GNT_CPU);

    always_comb begin
        gnt_p0 = GNT_NONE;
        if (cpu_elig && (starve_cnt == STARVE_MAX)) begin
            gnt_p0 = GNT_CPU;
        end else if (scan_elig) begin
            gnt_p0 = GNT_SCAN;
        end else if (dma_elig) begin
            gnt_p0 = GNT_DMA;
        end else if (cpu_elig) begin
            gnt_p0 = GNT_CPU;
        end
    end

    assign fifo_pop = (gnt_p0 == GNT_DMA);

    always_comb begin
        ram_addr  = addr_hold;
        ram_wdata = wdata_hold;
        ram_we    = 1'b0;
        case (gnt_p0)
            GNT_SCAN: ram_addr = scan_addr;
            GNT_DMA: begin
                ram_addr  = head_addr;
                ram_wdata = head_data;
                ram_we    = 1'b1;
            end
            GNT_CPU: begin
                ram_addr  = cpu_addr;
                ram_wdata = cpu_wdata;
                ram_we    = cpu_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_p1     <= GNT_NONE;
            cpu_rd_p1  <= 1'b0;
            starve_cnt <= '0;
            overflow_q <= 1'b0;
            addr_hold  <= '0;
            wdata_hold <= '0;
        end else begin
            gnt_p1     <= gnt_p0;
            cpu_rd_p1  <= (gnt_p0 == GNT_CPU) && !cpu_we;
            addr_hold  <= ram_addr;
            wdata_hold <= ram_wdata;
            if (gnt_p0 == GNT_CPU) begin
                starve_cnt <= '0;
            end else if (cpu_elig && (starve_cnt != STARVE_MAX)) begin
                starve_cnt <= starve_cnt + STARVE_W'(1);
            end
            if (dma_wr_en && fifo_full && !fifo_pop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Stage p1: acks and read data; the RAM returns data for the p0 address now.
    assign scan_ack     = (gnt_p1 == GNT_SCAN);
    assign cpu_ack      = (gnt_p1 == GNT_CPU);
    assign scan_rdata   = scan_ack ? ram_rdata : '0;
    assign cpu_rdata    = (cpu_ack && cpu_rd_p1) ? ram_rdata : '0;
    assign dma_overflow = overflow_q;

`ifdef PIXIE_VRAM_STATS_EN
    logic [15:0] conflict_cnt;
    logic [1:0]  n_elig;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign n_elig = 2'(scan_elig) + 2'(dma_elig) + 2'(cpu_elig);

    always_ff @(posedge clk) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (n_elig >= 2'd2) begin
            conflict_cnt <= sat_inc16(conflict_cnt);
        end
    end

    assign stat_conflicts = conflict_cnt;
`else
    assign stat_conflicts = 16'd0;
`endif

endmodule

// File: tb/tb_pixie_vram_arbiter.sv
// Directed bench for pixie_vram_arbiter: vector table plus multi-cycle sequences
// for overflow, starvation and reset, against a behavioural 1-cycle-latency RAM.
module tb_pixie_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dma_wr_en = 1'b0;
    logic [9:0]  dma_addr = '0;
    logic [7:0]  dma_data = '0;
    logic        dma_overflow;
    logic        scan_req = 1'b0;
    logic [9:0]  scan_addr = '0;
    logic        scan_ack;
    logic [7:0]  scan_rdata;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [9:0]  cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [9:0]  ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic [15:0] stat_conflicts;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:1023];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    pixie_vram_arbiter dut (
        .clk            (clk),
        .reset          (reset),
        .dma_wr_en      (dma_wr_en),
        .dma_addr       (dma_addr),
        .dma_data       (dma_data),
        .dma_overflow   (dma_overflow),
        .scan_req       (scan_req),
        .scan_addr      (scan_addr),
        .scan_ack       (scan_ack),
        .scan_rdata     (scan_rdata),
        .cpu_req        (cpu_req),
        .cpu_we         (cpu_we),
        .cpu_addr       (cpu_addr),
        .cpu_wdata      (cpu_wdata),
        .cpu_ack        (cpu_ack),
        .cpu_rdata      (cpu_rdata),
        .ram_addr       (ram_addr),
        .ram_we         (ram_we),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata),
        .stat_conflicts (stat_conflicts)
    );

    typedef struct {
        logic       dw;  logic [9:0] da;  logic [7:0] dd;
        logic       sr;  logic [9:0] sa;
        logic       cr;  logic       cw;  logic [9:0] ca;  logic [7:0] cd;
        logic       ew;  logic [9:0] ea;  logic [7:0] ed;
        logic       esa; logic [7:0] esd;
        logic       eca; logic [7:0] ecd;
        logic       eo;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];
    logic [15:0] stat_at [NV];

    function automatic vec_t mk(
        input logic dw, input logic [9:0] da, input logic [7:0] dd,
        input logic sr, input logic [9:0] sa,
        input logic cr, input logic cw, input logic [9:0] ca, input logic [7:0] cd,
        input logic ew, input logic [9:0] ea, input logic [7:0] ed,
        input logic esa, input logic [7:0] esd,
        input logic eca, input logic [7:0] ecd, input logic eo);
        vec_t v;
        v.dw = dw; v.da = da; v.dd = dd; v.sr = sr; v.sa = sa;
        v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
        v.ew = ew; v.ea = ea; v.ed = ed; v.esa = esa; v.esd = esd;
        v.eca = eca; v.ecd = ecd; v.eo = eo;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dma_wr_en = 1'b0; dma_addr = '0; dma_data = '0;
        scan_req = 1'b0; scan_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    endtask

    task automatic apply(input vec_t v);
        dma_wr_en = v.dw; dma_addr = v.da; dma_data = v.dd;
        scan_req = v.sr; scan_addr = v.sa;
        cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
    endtask

    // Leaves the bench #1 after a posedge with reset released.
    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("reset_state", 64'({scan_ack, cpu_ack, ram_we, dma_overflow, ram_addr, ram_wdata,
                                  scan_rdata, cpu_rdata, stat_conflicts}), 64'd0);
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected normal completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [17:0] wr_log [$];
        logic [9:0]  exp_a;
        int          first_ack;
        int          early_acks;
        int          nwr;
        logic [15:0] exp_delta;

        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h155] = 8'h3C;
        mem[10'h100] = 8'h9E;

        // Vector table: DMA burst, CPU read latency, three-way priority, read-back.
        vecs[0] = mk(1'b1,10'h000,8'hA0, 1'b0,10'h000, 1'b0,1'b0,10'h000,8'h00, 1'b0,10'h000,8'h00, 1'b0,8'h00, 1'b0,8'h00, 1'b0);
        for (int i = 1; i < 8; i++)
            vecs[i] = mk(1'b1,10'(i),8'hA0 + 8'(i), 1'b0,10'h000, 1'b0,1'b0,10'h000,8'h00,
                         1'b1,10'(i - 1),8'hA0 + 8'(i - 1), 1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[8]  = mk(1'b0,10'h000,8'h00, 1'b0,10'h000, 1'b0,1'b0,10'h000,8'h00, 1'b1,10'h007,8'hA7, 1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[9]  = mk(1'b0,10'h000,8'h00, 1'b0,10'h000, 1'b0,1'b0,10'h000,8'h00, 1'b0,10'h007,8'h00, 1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[10] = mk(1'b0,10'h000,8'h00, 1'b0,10'h000, 1'b1,1'b0,10'h155,8'h00, 1'b0,10'h155,8'h00, 1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[11] = mk(1'b0,10'h000,8'h00, 1'b0,10'h000, 1'b1,1'b0,10'h155,8'h00, 1'b0,10'h155,8'h00, 1'b0,8'h00, 1'b1,8'h3C, 1'b0);
        vecs[12] = mk(1'b0,10'h000,8'h00, 1'b0,10'h000, 1'b0,1'b0,10'h000,8'h00, 1'b0,10'h155,8'h00, 1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[13] = mk(1'b1,10'h020,8'h55, 1'b0,10'h000, 1'b0,1'b0,10'h000,8'h00, 1'b0,10'h155,8'h00, 1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[14] = mk(1'b0,10'h000,8'h00, 1'b1,10'h100, 1'b1,1'b1,10'h030,8'h77, 1'b0,10'h100,8'h00, 1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[15] = mk(1'b0,10'h000,8'h00, 1'b1,10'h100, 1'b1,1'b1,10'h030,8'h77, 1'b1,10'h020,8'h55, 1'b1,8'h9E, 1'b0,8'h00, 1'b0);
        vecs[16] = mk(1'b0,10'h000,8'h00, 1'b0,10'h000, 1'b1,1'b1,10'h030,8'h77, 1'b1,10'h030,8'h77, 1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[17] = mk(1'b0,10'h000,8'h00, 1'b0,10'h000, 1'b1,1'b1,10'h030,8'h77, 1'b0,10'h030,8'h00, 1'b0,8'h00, 1'b1,8'h00, 1'b0);
        vecs[18] = mk(1'b0,10'h000,8'h00, 1'b0,10'h000, 1'b0,1'b0,10'h000,8'h00, 1'b0,10'h030,8'h00, 1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[19] = mk(1'b0,10'h000,8'h00, 1'b0,10'h000, 1'b1,1'b0,10'h030,8'h00, 1'b0,10'h030,8'h00, 1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[20] = mk(1'b0,10'h000,8'h00, 1'b0,10'h000, 1'b1,1'b0,10'h030,8'h00, 1'b0,10'h030,8'h00, 1'b0,8'h00, 1'b1,8'h77, 1'b0);
        vecs[21] = mk(1'b0,10'h000,8'h00, 1'b1,10'h020, 1'b0,1'b0,10'h000,8'h00, 1'b0,10'h020,8'h00, 1'b0,8'h00, 1'b0,8'h00, 1'b0);
        vecs[22] = mk(1'b0,10'h000,8'h00, 1'b1,10'h020, 1'b0,1'b0,10'h000,8'h00, 1'b0,10'h020,8'h00, 1'b1,8'h55, 1'b0,8'h00, 1'b0);
        vecs[23] = mk(1'b0,10'h000,8'h00, 1'b0,10'h000, 1'b0,1'b0,10'h000,8'h00, 1'b0,10'h020,8'h00, 1'b0,8'h00, 1'b0,8'h00, 1'b0);

        do_reset();

        for (int i = 0; i < NV; i++) begin
            logic rd_chk;
            apply(vecs[i]);
            @(negedge clk);
            rd_chk = vecs[i].eca && !vecs[i].cw;
            stat_at[i] = stat_conflicts;
            check($sformatf("vec%0d", i),
                  64'({ram_we, ram_addr, vecs[i].ew ? ram_wdata : 8'h00, scan_ack,
                       vecs[i].esa ? scan_rdata : 8'h00, cpu_ack, rd_chk ? cpu_rdata : 8'h00, dma_overflow}),
                  64'({vecs[i].ew, vecs[i].ea, vecs[i].ew ? vecs[i].ed : 8'h00, vecs[i].esa,
                       vecs[i].esa ? vecs[i].esd : 8'h00, vecs[i].eca, rd_chk ? vecs[i].ecd : 8'h00, vecs[i].eo}));
            next_cycle();
        end

`ifdef PIXIE_VRAM_STATS_EN
        exp_delta = 16'd1;
`else
        exp_delta = 16'd0;
`endif
        check("stat_priority_delta", 64'(stat_at[15] - stat_at[14]), 64'(exp_delta));

        // Overflow: scan held keeps DMA to every other cycle while 10 pulses arrive.
        idle_inputs();
        for (int c = 0; c < 16; c++) begin
            scan_req  = (c < 12);
            scan_addr = 10'h200;
            dma_wr_en = (c < 10);
            dma_addr  = 10'h040 + 10'(c);
            dma_data  = 8'hB0 + 8'(c);
            @(negedge clk);
            if (ram_we) wr_log.push_back({ram_addr, ram_wdata});
            if (c == 8) check("ovf_before_drop", 64'(dma_overflow), 64'd0);
            if (c == 9) check("ovf_after_drop", 64'(dma_overflow), 64'd1);
            next_cycle();
        end
        idle_inputs();
        nwr = wr_log.size();
        check("ovf_write_count", 64'(nwr), 64'd9);
        for (int k = 0; k < 9; k++) begin
            exp_a = (k < 8) ? 10'h040 + 10'(k) : 10'h049;
            if (k < nwr)
                check($sformatf("ovf_write%0d", k), 64'(wr_log[k]), 64'({exp_a, 8'hB0 + exp_a[7:0] - 8'h40}));
        end
        check("ovf_sticky", 64'(dma_overflow), 64'd1);

        do_reset();

        // Starvation: scan and DMA alternate until the CPU is promoted.
        first_ack  = -1;
        early_acks = 0;
        for (int c = 0; c < 10; c++) begin
            scan_req = 1'b1; scan_addr = 10'h100;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h155;
            dma_wr_en = (c < 8); dma_addr = 10'h060 + 10'(c); dma_data = 8'(c);
            @(negedge clk);
            if (cpu_ack && c < 9) early_acks++;
            if (cpu_ack && first_ack < 0) first_ack = c;
            if (c == 8) check("starve_grant", 64'({ram_we, ram_addr}), 64'({1'b0, 10'h155}));
            if (c == 9) begin
                check("starve_ack", 64'({cpu_ack, cpu_rdata}), 64'({1'b1, 8'h3C}));
                check("starve_cleared", 64'(dut.starve_cnt), 64'd0);
            end
            next_cycle();
        end
        check("starve_no_early_ack", 64'(early_acks), 64'd0);
        check("starve_first_ack_cycle", 64'(first_ack), 64'd9);

        do_reset();

        // Reset with a CPU read pending and three posted DMA writes.
        nwr = 0;
        for (int c = 0; c < 5; c++) begin
            scan_req = 1'b1; scan_addr = 10'h100;
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h155;
            dma_wr_en = 1'b1; dma_addr = 10'h070 + 10'(c); dma_data = 8'h10 + 8'(c);
            @(negedge clk);
            if (ram_we) nwr++;
            next_cycle();
        end
        check("rst_pre_writes", 64'(nwr), 64'd2);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        check("rst_cycle_no_write", 64'({ram_we, cpu_ack && cpu_rdata != 8'h00}), 64'd0);
        next_cycle();
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check($sformatf("rst_quiet%0d", c), 64'({ram_we, cpu_ack, scan_ack, dma_overflow}), 64'd0);
            next_cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
